regfile_access_ctrl: RTL and testbench

Controller in front of the 8-entry x 32-bit register file, which has one synchronous write port and registered read ports. It arbitrates the single write port round-robin between the core writeback path and a debug/loader requester. It also sequences a debug "dump" that reads all registers out in order while writes are frozen. All register-file control signals are driven by this block; the core read address passes through when no dump is in progress.

---
 rtl/regfile_access_ctrl.sv | 122 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Write-port arbiter and debug dump sequencer for the 8 x 32 register file.
// Core and debug writers share one port round-robin; a dump freezes writes and streams every register.
module regfile_access_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_rs,
    input  logic              core_wr_valid,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic              core_wr_ready,
    input  logic              dbg_wr_valid,
    input  logic [ADDR_W-1:0] dbg_wr_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic              dbg_wr_ready,
    output logic              wr_err,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [2:0]        dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic [ADDR_W-1:0] rf_rs,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_a
);

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [2:0]      LAST_IDX  = 3'(NUM_REGS - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic              favor_core;

    logic              arb_open;
    logic              grant_core;
    logic              grant_dbg;
    logic              xfer;
    logic              xfer_in_range;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    // The pointer only matters on contention; a lone requester is always granted.
    always_comb begin
        arb_open      = (state == IDLE) && !dump_start;
        grant_core    = arb_open && core_wr_valid && (!dbg_wr_valid || favor_core);
        grant_dbg     = arb_open && dbg_wr_valid && (!core_wr_valid || !favor_core);
        xfer          = grant_core || grant_dbg;
        xfer_addr     = grant_core ? core_wr_addr : dbg_wr_addr;
        xfer_data     = grant_core ? core_wr_data : dbg_wr_data;
        xfer_in_range = ({1'b0, xfer_addr} < REG_LIMIT);
    end

    assign core_wr_ready = grant_core;
    assign dbg_wr_ready  = grant_dbg;
    assign dump_busy     = (state != IDLE);
    assign rf_rs         = (state == READ) ? ADDR_W'(cnt) : core_rs;
    assign dump_data     = dump_valid ? rf_a : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt   <= '0;
                    state <= READ;
                end
                READ: begin
                    // rf_a lags rf_rs by one cycle, so the index is registered alongside it.
                    dump_valid <= 1'b1;
                    dump_index <= cnt;
                    dump_done  <= (cnt == LAST_IDX);
                    cnt        <= cnt + 3'd1;
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_RegWrite   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            wr_err        <= 1'b0;
            favor_core    <= 1'b1;
        end else begin
            rf_RegWrite <= xfer && xfer_in_range;
            wr_err      <= xfer && !xfer_in_range;
            if (xfer && xfer_in_range) begin
                rf_write_reg  <= xfer_addr;
                rf_write_data <= xfer_data;
            end
            if (xfer && core_wr_valid && dbg_wr_valid) begin
                favor_core <= grant_dbg;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: vector table, directed dump sequences,
// and randomized traffic against a timeline-based reference model.
module tb_regfile_access_ctrl;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] core_rs;
    logic              core_wr_valid;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_wr_ready;
    logic              dbg_wr_valid;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic              dbg_wr_ready;
    logic              wr_err;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic [2:0]        dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;
    logic [ADDR_W-1:0] rf_rs;
    logic              rf_RegWrite;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_a;

    int checks = 0;
    int errors = 0;

    regfile_access_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .core_rs(core_rs),
        .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data), .core_wr_ready(core_wr_ready),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_addr(dbg_wr_addr),
        .dbg_wr_data(dbg_wr_data), .dbg_wr_ready(dbg_wr_ready),
        .wr_err(wr_err), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_index(dump_index), .dump_data(dump_data),
        .dump_done(dump_done), .rf_rs(rf_rs), .rf_RegWrite(rf_RegWrite),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_a(rf_a)
    );

    always #5 clk = ~clk;

    // Register file: registered read sampled before the same-edge write.
    logic [DATA_W-1:0] rf_mem [NUM_REGS] = '{default: '0};
    always @(posedge clk) begin
        rf_a <= (32'(rf_rs) < NUM_REGS) ? rf_mem[rf_rs[2:0]] : '0;
        if (rf_RegWrite && 32'(rf_write_reg) < NUM_REGS)
            rf_mem[rf_write_reg[2:0]] <= rf_write_data;
    end

    typedef struct {
        bit                cv;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        bit                dv;
        logic [ADDR_W-1:0] da;
        logic [DATA_W-1:0] dd;
        bit                ds;
        logic [ADDR_W-1:0] rs;
        bit                rst;
    } stim_t;

    typedef struct {
        stim_t             in;
        bit                exp_cr;
        bit                exp_dr;
        bit                exp_we;
        logic [ADDR_W-1:0] exp_reg;
        logic [DATA_W-1:0] exp_data;
        bit                exp_err;
    } vec_t;

    // Reference model: dump progress is the age in cycles since the accepted start.
    int                m_age = -1;
    bit                m_favor_core = 1'b1;
    bit                m_we = 1'b0;
    bit                m_err = 1'b0;
    logic [ADDR_W-1:0] m_reg = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_gc;
    bit                m_gd;
    logic [DATA_W-1:0] shadow [NUM_REGS] = '{default: '0};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{cv: 1'b0, ca: '0, cd: '0, dv: 1'b0, da: '0, dd: '0, ds: 1'b0, rs: '0, rst: 1'b0};
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s, input bit mcheck);
        bit                busy;
        bit                e_dv;
        bit                start;
        int                e_idx;
        logic [ADDR_W-1:0] e_rs;
        logic [ADDR_W-1:0] w_addr;
        @(posedge clk);
        #1;
        reset         = s.rst;
        core_wr_valid = s.cv;
        core_wr_addr  = s.ca;
        core_wr_data  = s.cd;
        dbg_wr_valid  = s.dv;
        dbg_wr_addr   = s.da;
        dbg_wr_data   = s.dd;
        dump_start    = s.ds;
        core_rs       = s.rs;
        busy  = (m_age >= 1 && m_age <= 9);
        e_dv  = (m_age >= 3 && m_age <= 10);
        e_idx = e_dv ? m_age - 3 : 0;
        e_rs  = (m_age >= 2 && m_age <= 9) ? ADDR_W'(m_age - 2) : s.rs;
        start = !busy && s.ds;
        m_gc  = !busy && !s.ds && s.cv && (!s.dv || m_favor_core);
        m_gd  = !busy && !s.ds && s.dv && (!s.cv || !m_favor_core);
        #3;
        if (mcheck) begin
            checkOutput("m_core_ready", 32'(core_wr_ready), 32'(m_gc));
            checkOutput("m_dbg_ready", 32'(dbg_wr_ready), 32'(m_gd));
            checkOutput("m_regwrite", 32'(rf_RegWrite), 32'(m_we));
            checkOutput("m_wr_err", 32'(wr_err), 32'(m_err));
            checkOutput("m_write_reg", 32'(rf_write_reg), 32'(m_reg));
            checkOutput("m_write_data", rf_write_data, m_data);
            checkOutput("m_dump_busy", 32'(dump_busy), 32'(busy));
            checkOutput("m_dump_valid", 32'(dump_valid), 32'(e_dv));
            checkOutput("m_dump_done", 32'(dump_done), 32'(m_age == 10));
            checkOutput("m_dump_data", dump_data, e_dv ? shadow[e_idx] : 32'h0);
            checkOutput("m_rf_rs", 32'(rf_rs), 32'(e_rs));
            if (e_dv) checkOutput("m_dump_index", 32'(dump_index), 32'(e_idx));
        end
        if (m_we) shadow[m_reg[2:0]] = m_data;
        if (s.rst) begin
            m_age = -1; m_favor_core = 1'b1;
            m_we = 1'b0; m_err = 1'b0; m_reg = '0; m_data = '0;
        end else begin
            if (s.cv && s.dv && (m_gc || m_gd)) m_favor_core = m_gd;
            m_we = 1'b0;
            m_err = 1'b0;
            if (m_gc || m_gd) begin
                w_addr = m_gc ? s.ca : s.da;
                if (32'(w_addr) < NUM_REGS) begin
                    m_we = 1'b1; m_reg = w_addr; m_data = m_gc ? s.cd : s.dd;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_age = start ? 1 : ((m_age >= 1 && m_age < 10) ? m_age + 1 : -1);
        end
    endtask

    function automatic vec_t mkv(bit cv, logic [ADDR_W-1:0] ca, logic [DATA_W-1:0] cd,
                                 bit dv, logic [ADDR_W-1:0] da, logic [DATA_W-1:0] dd,
                                 bit ecr, bit edr, bit ewe, logic [ADDR_W-1:0] ereg,
                                 logic [DATA_W-1:0] edata, bit eerr);
        vec_t v;
        v.in = idleStim();
        v.in.cv = cv; v.in.ca = ca; v.in.cd = cd;
        v.in.dv = dv; v.in.da = da; v.in.dd = dd;
        v.exp_cr = ecr; v.exp_dr = edr; v.exp_we = ewe;
        v.exp_reg = ereg; v.exp_data = edata; v.exp_err = eerr;
        return v;
    endfunction

    initial begin
        vec_t  vecs [11];
        stim_t s;
        int    nvalid;
        int    ndone;
        bit    hold_c;
        bit    hold_d;

        // Expected registered outputs in each row reflect the transfer of the previous row.
        vecs[0]  = mkv(1, 5'd3, 32'hAA,   0, 5'd0, 32'h0,    1, 0, 0, 5'd0, 32'h0,   0);
        vecs[1]  = mkv(1, 5'd1, 32'h101,  1, 5'd2, 32'h202,  1, 0, 1, 5'd3, 32'hAA,  0);
        vecs[2]  = mkv(1, 5'd1, 32'h101,  1, 5'd2, 32'h202,  0, 1, 1, 5'd1, 32'h101, 0);
        vecs[3]  = mkv(1, 5'd1, 32'h101,  1, 5'd2, 32'h202,  1, 0, 1, 5'd2, 32'h202, 0);
        vecs[4]  = mkv(1, 5'd1, 32'h101,  1, 5'd2, 32'h202,  0, 1, 1, 5'd1, 32'h101, 0);
        vecs[5]  = mkv(0, 5'd0, 32'h0,    1, 5'd9, 32'hDEAD, 0, 1, 1, 5'd2, 32'h202, 0);
        vecs[6]  = mkv(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 5'd2, 32'h202, 1);
        vecs[7]  = mkv(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 5'd2, 32'h202, 0);
        vecs[8]  = mkv(1, 5'd7, 32'h77,   1, 5'd7, 32'h99,   1, 0, 0, 5'd2, 32'h202, 0);
        vecs[9]  = mkv(0, 5'd0, 32'h0,    1, 5'd6, 32'h66,   0, 1, 1, 5'd7, 32'h77,  0);
        vecs[10] = mkv(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 1, 5'd6, 32'h66,  0);

        reset = 1'b1; core_rs = '0; dump_start = 1'b0;
        core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
        dbg_wr_valid = 1'b0; dbg_wr_addr = '0; dbg_wr_data = '0;

        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b0);
        applyStimulus(idleStim(), 1'b1);
        checkOutput("rst_regwrite", 32'(rf_RegWrite), 32'h0);
        checkOutput("rst_write_reg", 32'(rf_write_reg), 32'h0);
        checkOutput("rst_write_data", rf_write_data, 32'h0);
        checkOutput("rst_wr_err", 32'(wr_err), 32'h0);
        checkOutput("rst_dump_valid", 32'(dump_valid), 32'h0);
        checkOutput("rst_dump_done", 32'(dump_done), 32'h0);
        checkOutput("rst_dump_index", 32'(dump_index), 32'h0);
        checkOutput("rst_dump_busy", 32'(dump_busy), 32'h0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].in, 1'b1);
            checkOutput($sformatf("vec%0d_core_ready", i), 32'(core_wr_ready), 32'(vecs[i].exp_cr));
            checkOutput($sformatf("vec%0d_dbg_ready", i), 32'(dbg_wr_ready), 32'(vecs[i].exp_dr));
            checkOutput($sformatf("vec%0d_regwrite", i), 32'(rf_RegWrite), 32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_write_reg", i), 32'(rf_write_reg), 32'(vecs[i].exp_reg));
            checkOutput($sformatf("vec%0d_write_data", i), rf_write_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].exp_err));
        end

        // Preload 0x10..0x17, then dump with the core requesting throughout.
        for (int i = 0; i < NUM_REGS; i++) begin
            s = idleStim();
            s.cv = 1'b1; s.ca = ADDR_W'(i); s.cd = 32'h10 + 32'(i);
            applyStimulus(s, 1'b1);
        end
        applyStimulus(idleStim(), 1'b1);
        for (int k = 0; k <= 10; k++) begin
            s = idleStim();
            s.cv = 1'b1; s.ca = 5'd5; s.cd = 32'hBAD; s.rs = 5'd31; s.ds = (k == 0);
            applyStimulus(s, 1'b1);
            checkOutput("dumpA_busy", 32'(dump_busy), 32'(k >= 1 && k <= 9));
            checkOutput("dumpA_valid", 32'(dump_valid), 32'(k >= 3));
            checkOutput("dumpA_done", 32'(dump_done), 32'(k == 10));
            if (k <= 9) checkOutput("dumpA_core_ready", 32'(core_wr_ready), 32'h0);
            if (k >= 2 && k <= 9) checkOutput("dumpA_rf_rs", 32'(rf_rs), 32'(k - 2));
            if (k >= 3) begin
                checkOutput("dumpA_index", 32'(dump_index), 32'(k - 3));
                checkOutput("dumpA_data", dump_data, 32'h10 + 32'(k - 3));
            end
        end
        applyStimulus(idleStim(), 1'b1);
        applyStimulus(idleStim(), 1'b1);

        // A write accepted just before dump_start must show up in the dump.
        s = idleStim();
        s.cv = 1'b1; s.ca = 5'd4; s.cd = 32'h55;
        applyStimulus(s, 1'b1);
        checkOutput("dumpB_pre_ready", 32'(core_wr_ready), 32'h1);
        for (int k = 0; k <= 10; k++) begin
            s = idleStim();
            s.ds = (k == 0);
            applyStimulus(s, 1'b1);
            if (k == 7) begin
                checkOutput("dumpB_index4", 32'(dump_index), 32'h4);
                checkOutput("dumpB_data4", dump_data, 32'h55);
            end
        end

        // Reset in cycle 5 of a dump aborts it; a fresh dump then runs in full.
        for (int k = 0; k <= 12; k++) begin
            s = idleStim();
            s.ds  = (k == 0);
            s.rst = (k == 5);
            applyStimulus(s, 1'b1);
            if (k == 6) begin
                checkOutput("abort_busy", 32'(dump_busy), 32'h0);
                checkOutput("abort_valid", 32'(dump_valid), 32'h0);
            end
            if (k >= 6) checkOutput("abort_done", 32'(dump_done), 32'h0);
        end
        nvalid = 0;
        ndone  = 0;
        for (int k = 0; k <= 12; k++) begin
            s = idleStim();
            s.ds = (k == 0);
            applyStimulus(s, 1'b1);
            if (dump_valid) nvalid++;
            if (dump_done) ndone++;
        end
        checkOutput("redump_valid_count", 32'(nvalid), 32'd8);
        checkOutput("redump_done_count", 32'(ndone), 32'd1);

        // Random traffic; a requester keeps its request stable until the model grants it.
        s = idleStim();
        hold_c = 1'b0;
        hold_d = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!hold_c) begin
                s.cv = ($urandom_range(0, 2) != 0);
                s.ca = ADDR_W'($urandom_range(0, 9));
                s.cd = $urandom;
            end
            if (!hold_d) begin
                s.dv = ($urandom_range(0, 2) != 0);
                s.da = ADDR_W'($urandom_range(0, 9));
                s.dd = $urandom;
            end
            s.ds  = ($urandom_range(0, 19) == 0);
            s.rs  = ADDR_W'($urandom_range(0, 31));
            s.rst = ($urandom_range(0, 149) == 0);
            applyStimulus(s, 1'b1);
            hold_c = s.cv && !m_gc && !s.rst;
            hold_d = s.dv && !m_gd && !s.rst;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
